// File: rtl/rx_d2c_point_test_responder_if.sv
// Sideband, wrapper-handshake and comparator bundle between the RX D2C point-test responder and its neighbours.
interface rx_d2c_point_test_responder_if #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int NUM_LANES    = 16
);
  logic                    i_rx_d2c_pt_en;
  logic                    i_rx_msg_valid;
  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg;
  logic                    i_sb_data_pattern;
  logic                    i_sb_burst_count;
  logic                    i_sb_comparison_mode;
  logic [1:0]              i_sb_clock_phase;
  logic                    i_falling_edge_busy;
  logic                    i_tx_valid;
  logic [NUM_LANES-1:0]    i_lane_errors;
  logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx;
  logic                    o_valid_rx;
  logic [1:0]              o_comparator_cw;
  logic                    o_cmp_data_pattern;
  logic                    o_cmp_burst_count;
  logic                    o_cmp_comparison_mode;
  logic [1:0]              o_clock_phase;
  logic [NUM_LANES-1:0]    o_lane_result;
  logic                    o_rx_d2c_pt_done_rx;
  logic                    o_timeout;

  modport master (
    output i_rx_d2c_pt_en, i_rx_msg_valid, i_decoded_SB_msg, i_sb_data_pattern,
           i_sb_burst_count, i_sb_comparison_mode, i_sb_clock_phase,
           i_falling_edge_busy, i_tx_valid, i_lane_errors,
    input  o_encoded_SB_msg_rx, o_valid_rx, o_comparator_cw, o_cmp_data_pattern,
           o_cmp_burst_count, o_cmp_comparison_mode, o_clock_phase, o_lane_result,
           o_rx_d2c_pt_done_rx, o_timeout
  );

  modport slave (
    input  i_rx_d2c_pt_en, i_rx_msg_valid, i_decoded_SB_msg, i_sb_data_pattern,
           i_sb_burst_count, i_sb_comparison_mode, i_sb_clock_phase,
           i_falling_edge_busy, i_tx_valid, i_lane_errors,
    output o_encoded_SB_msg_rx, o_valid_rx, o_comparator_cw, o_cmp_data_pattern,
           o_cmp_burst_count, o_cmp_comparison_mode, o_clock_phase, o_lane_result,
           o_rx_d2c_pt_done_rx, o_timeout
  );
endinterface

// File: rtl/rx_d2c_point_test_responder.sv
// Responder for the partner-initiated RX D2C point test: answers sideband requests, drives the comparator, latches lane results.
// Optional wait-state timeout enabled by defining RX_D2C_PT_TIMEOUT_EN.
module rx_d2c_lane_result (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_cap,
  input  logic i_err,
  output logic o_res
);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   o_res <= 1'b0;
    else if (i_clr) o_res <= 1'b0;
    else if (i_cap) o_res <= i_err;
  end
endmodule

module rx_d2c_point_test_responder #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int NUM_LANES      = 16,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  rx_d2c_point_test_responder_if.slave bus
);
  typedef logic [SB_MSG_WIDTH-1:0] msg_t;
  localparam msg_t START_REQ       = msg_t'(1);
  localparam msg_t START_RESP      = msg_t'(2);
  localparam msg_t LFSR_CLR_REQ    = msg_t'(3);
  localparam msg_t LFSR_CLR_RESP   = msg_t'(4);
  localparam msg_t COUNT_DONE_REQ  = msg_t'(5);
  localparam msg_t COUNT_DONE_RESP = msg_t'(6);
  localparam msg_t END_REQ         = msg_t'(7);
  localparam msg_t END_RESP        = msg_t'(8);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, WAIT_CLR, CLEAR, COMPARE, WAIT_END, FINISHED
  } state_t;

  typedef struct packed {
    logic       pattern;
    logic       burst;
    logic       mode;
    logic [1:0] phase;
  } start_f_t;

  state_t   state_q, state_d;
  logic     en, acc_start, acc_clr, acc_cnt, acc_end;
  logic     send, take_start, latch_res, set_done, to_hit;
  msg_t     resp;
  logic     pend_q;
  start_f_t pend_f_q, fld_q, live_f;
  msg_t     enc_q;
  logic     vld_q, done_q;
  logic [1:0] cw_q, cw_d;

  assign en        = bus.i_rx_d2c_pt_en;
  assign acc_start = bus.i_rx_msg_valid && (bus.i_decoded_SB_msg == START_REQ);
  assign acc_clr   = bus.i_rx_msg_valid && (bus.i_decoded_SB_msg == LFSR_CLR_REQ);
  assign acc_cnt   = bus.i_rx_msg_valid && (bus.i_decoded_SB_msg == COUNT_DONE_REQ);
  assign acc_end   = bus.i_rx_msg_valid && (bus.i_decoded_SB_msg == END_REQ);

  assign live_f.pattern = bus.i_sb_data_pattern;
  assign live_f.burst   = bus.i_sb_burst_count;
  assign live_f.mode    = bus.i_sb_comparison_mode;
  assign live_f.phase   = bus.i_sb_clock_phase;

`ifdef RX_D2C_PT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             to_q, is_wait;
  assign is_wait = (state_q == WAIT_START) || (state_q == WAIT_CLR) ||
                   (state_q == COMPARE)    || (state_q == WAIT_END);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    send       = 1'b0;
    resp       = '0;
    take_start = 1'b0;
    latch_res  = 1'b0;
    set_done   = 1'b0;
    to_hit     = 1'b0;
    case (state_q)
      IDLE:       if (en) state_d = WAIT_START;
      // a START_REQ seen while still idle counts as accepted here
      WAIT_START: if (acc_start || pend_q) begin
                    state_d = WAIT_CLR; send = 1'b1; resp = START_RESP; take_start = 1'b1;
                  end
      WAIT_CLR:   if (acc_clr) begin
                    state_d = CLEAR; send = 1'b1; resp = LFSR_CLR_RESP;
                  end
      CLEAR:      state_d = COMPARE;
      COMPARE:    if (acc_cnt) begin
                    state_d = WAIT_END; send = 1'b1; resp = COUNT_DONE_RESP; latch_res = 1'b1;
                  end
      WAIT_END:   if (acc_end) begin
                    state_d = FINISHED; send = 1'b1; resp = END_RESP; set_done = 1'b1;
                  end
      FINISHED:   state_d = FINISHED;
      default:    state_d = IDLE;
    endcase
`ifdef RX_D2C_PT_TIMEOUT_EN
    if (is_wait && (state_d == state_q) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = FINISHED;
      to_hit  = 1'b1;
    end
`endif
    // enable dropping overrides any accept in the same cycle
    if (!en) begin
      state_d    = IDLE;
      send       = 1'b0;
      resp       = '0;
      take_start = 1'b0;
      latch_res  = 1'b0;
      set_done   = 1'b0;
      to_hit     = 1'b0;
    end
  end

  always_comb begin
    cw_d = 2'b00;
    if (state_d == CLEAR)   cw_d = 2'b01;
    if (state_d == COMPARE) cw_d = 2'b10;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q   <= 1'b0;
      pend_f_q <= '0;
    end else if (!en && (state_q != IDLE)) begin
      pend_q   <= 1'b0;
    end else if (take_start) begin
      pend_q   <= 1'b0;
    end else if ((state_q == IDLE) && acc_start) begin
      pend_q   <= 1'b1;
      pend_f_q <= live_f;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= 1'b0;
      cw_q   <= 2'b00;
      enc_q  <= '0;
      fld_q  <= '0;
      done_q <= 1'b0;
    end else begin
      // set wins over the wrapper's clear
      if (send)                                          vld_q <= 1'b1;
      else if (bus.i_falling_edge_busy && !bus.i_tx_valid) vld_q <= 1'b0;
      cw_q <= cw_d;
      if (state_q == IDLE) begin
        enc_q  <= '0;
        fld_q  <= '0;
        done_q <= 1'b0;
      end else begin
        if (send)               enc_q  <= resp;
        if (take_start)         fld_q  <= acc_start ? live_f : pend_f_q;
        if (set_done || to_hit) done_q <= 1'b1;
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rx_d2c_lane_result u_res (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (state_q == IDLE),
      .i_cap   (latch_res),
      .i_err   (bus.i_lane_errors[l]),
      .o_res   (bus.o_lane_result[l])
    );
  end

`ifdef RX_D2C_PT_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (state_d != state_q) cnt_q <= '0;
      else if (is_wait)       cnt_q <= cnt_q + 1'b1;
      if (state_q == IDLE)    to_q  <= 1'b0;
      else if (to_hit)        to_q  <= 1'b1;
    end
  end
  assign bus.o_timeout = to_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_encoded_SB_msg_rx   = enc_q;
  assign bus.o_valid_rx            = vld_q;
  assign bus.o_comparator_cw       = cw_q;
  assign bus.o_cmp_data_pattern    = fld_q.pattern;
  assign bus.o_cmp_burst_count     = fld_q.burst;
  assign bus.o_cmp_comparison_mode = fld_q.mode;
  assign bus.o_clock_phase         = fld_q.phase;
  assign bus.o_rx_d2c_pt_done_rx   = done_q;
endmodule

// File: tb/tb_rx_d2c_point_test_responder.sv
// Bench for the RX D2C point-test responder: directed protocol scenarios plus random traffic against a progress-based reference model.
module tb_rx_d2c_point_test_responder;
  localparam int W  = 4;
  localparam int NL = 16;
`ifdef RX_D2C_PT_TIMEOUT_EN
  localparam int TO    = 20;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TO    = 800000;
  localparam bit TO_ON = 1'b0;
`endif

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  rx_d2c_point_test_responder_if #(.SB_MSG_WIDTH(W), .NUM_LANES(NL)) bus ();

  rx_d2c_point_test_responder #(
    .SB_MSG_WIDTH(W), .NUM_LANES(NL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: progress = number of requests answered in order 1,3,5,7.
  bit          m_act = 0, m_pend = 0, m_clr_now = 0, m_to = 0;
  int          m_prog = 0, m_cnt = 0;
  logic [4:0]  m_pf = '0;
  logic [W-1:0]  e_msg = '0;
  logic          e_vld = 0, e_done = 0, e_to = 0;
  logic [1:0]    e_cw = '0;
  logic [4:0]    e_fld = '0;   // {pattern, burst, mode, phase}
  logic [NL-1:0] e_res = '0;

  task automatic model_step();
    bit         en, vld, send;
    int         code, want;
    logic [4:0] live;
    en   = bus.i_rx_d2c_pt_en;
    vld  = bus.i_rx_msg_valid;
    code = int'(bus.i_decoded_SB_msg);
    live = {bus.i_sb_data_pattern, bus.i_sb_burst_count, bus.i_sb_comparison_mode, bus.i_sb_clock_phase};
    send = 0;
    if (!m_act) begin
      e_msg = '0; e_fld = '0; e_res = '0; e_done = 0; e_to = 0; e_cw = 2'd0;
      if (vld && code == 1) begin m_pend = 1; m_pf = live; end
      if (en) begin m_act = 1; m_prog = 0; m_clr_now = 0; m_to = 0; m_cnt = 0; end
    end else if (!en) begin
      m_act = 0; m_pend = 0; e_cw = 2'd0;
    end else begin
      if (m_clr_now) begin
        m_clr_now = 0; m_cnt = 0;
      end else if (m_prog < 4 && !m_to) begin
        want = 2 * m_prog + 1;
        if ((vld && code == want) || (m_prog == 0 && m_pend)) begin
          send  = 1;
          e_msg = W'(want + 1);
          m_cnt = 0;
          case (m_prog)
            0: begin e_fld = (vld && code == 1) ? live : m_pf; m_pend = 0; end
            1: m_clr_now = 1;
            2: e_res = bus.i_lane_errors;
            default: e_done = 1;
          endcase
          m_prog++;
        end else if (TO_ON && m_cnt == TO - 1) begin
          m_to = 1; e_to = 1; e_done = 1;
        end else begin
          m_cnt++;
        end
      end
      e_cw = m_clr_now ? 2'd1 : ((m_prog == 2 && !m_to) ? 2'd2 : 2'd0);
    end
    if (send) e_vld = 1;
    else if (bus.i_falling_edge_busy && !bus.i_tx_valid) e_vld = 0;
  endtask

  task automatic compare_all();
    chk("enc",     32'(bus.o_encoded_SB_msg_rx), 32'(e_msg));
    chk("valid",   32'(bus.o_valid_rx),          32'(e_vld));
    chk("cw",      32'(bus.o_comparator_cw),     32'(e_cw));
    chk("fields",  32'({bus.o_cmp_data_pattern, bus.o_cmp_burst_count, bus.o_cmp_comparison_mode,
                        bus.o_clock_phase}),     32'(e_fld));
    chk("result",  32'(bus.o_lane_result),       32'(e_res));
    chk("done",    32'(bus.o_rx_d2c_pt_done_rx), 32'(e_done));
    chk("timeout", 32'(bus.o_timeout),           32'(e_to));
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic msg(input int code);
    bus.i_rx_msg_valid   = 1'b1;
    bus.i_decoded_SB_msg = W'(code);
    tick();
    bus.i_rx_msg_valid   = 1'b0;
    bus.i_decoded_SB_msg = '0;
  endtask

  initial begin
    bus.i_rx_d2c_pt_en       = 1'b0;
    bus.i_rx_msg_valid       = 1'b0;
    bus.i_decoded_SB_msg     = '0;
    bus.i_sb_data_pattern    = 1'b0;
    bus.i_sb_burst_count     = 1'b0;
    bus.i_sb_comparison_mode = 1'b0;
    bus.i_sb_clock_phase     = 2'd0;
    bus.i_falling_edge_busy  = 1'b0;
    bus.i_tx_valid           = 1'b0;
    bus.i_lane_errors        = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_enc",    32'(bus.o_encoded_SB_msg_rx), 0);
    chk("rst_valid",  32'(bus.o_valid_rx),          0);
    chk("rst_cw",     32'(bus.o_comparator_cw),     0);
    chk("rst_result", 32'(bus.o_lane_result),       0);
    chk("rst_done",   32'(bus.o_rx_d2c_pt_done_rx), 0);
    chk("rst_to",     32'(bus.o_timeout),           0);
    i_rst_n = 1'b1;
    tick();

    // full handshake and comparator control
    bus.i_rx_d2c_pt_en   = 1'b1; tick();
    bus.i_sb_burst_count = 1'b1;
    bus.i_sb_clock_phase = 2'd2;
    msg(1);
    chk("hs_start_resp", 32'(bus.o_encoded_SB_msg_rx), 2);
    chk("hs_valid",      32'(bus.o_valid_rx),          1);
    chk("hs_phase",      32'(bus.o_clock_phase),       2);
    chk("hs_burst",      32'(bus.o_cmp_burst_count),   1);
    repeat (2) tick();
    msg(3);
    chk("hs_clr_resp", 32'(bus.o_encoded_SB_msg_rx), 4);
    chk("cw_clear",    32'(bus.o_comparator_cw),     1);
    tick();
    chk("cw_cmp_first", 32'(bus.o_comparator_cw), 2);
    repeat (3) tick();
    chk("cw_cmp_hold", 32'(bus.o_comparator_cw), 2);
    bus.i_lane_errors = 16'h0004;
    msg(5);
    bus.i_lane_errors = '0;
    chk("hs_cnt_resp", 32'(bus.o_encoded_SB_msg_rx), 6);
    chk("lane_result", 32'(bus.o_lane_result),       32'h0004);
    chk("cw_after",    32'(bus.o_comparator_cw),     0);
    msg(7);
    chk("hs_end_resp", 32'(bus.o_encoded_SB_msg_rx), 8);
    chk("hs_done",     32'(bus.o_rx_d2c_pt_done_rx), 1);

    // valid arbitration against the co-located initiator
    bus.i_falling_edge_busy = 1'b1; bus.i_tx_valid = 1'b1; tick();
    chk("va_keep", 32'(bus.o_valid_rx), 1);
    bus.i_tx_valid = 1'b0; tick();
    chk("va_clear", 32'(bus.o_valid_rx), 0);
    bus.i_falling_edge_busy = 1'b0;

    // done drops the cycle after IDLE is entered
    bus.i_rx_d2c_pt_en = 1'b0; tick();
    chk("done_hold", 32'(bus.o_rx_d2c_pt_done_rx), 1);
    tick();
    chk("done_drop", 32'(bus.o_rx_d2c_pt_done_rx), 0);

    // abort during COMPARE
    bus.i_rx_d2c_pt_en = 1'b1; tick();
    msg(1); msg(3); tick();
    bus.i_lane_errors  = 16'hffff;
    bus.i_rx_d2c_pt_en = 1'b0; tick(); tick();
    chk("ab_cw",     32'(bus.o_comparator_cw),     0);
    chk("ab_result", 32'(bus.o_lane_result),       0);
    chk("ab_enc",    32'(bus.o_encoded_SB_msg_rx), 0);
    bus.i_falling_edge_busy = 1'b1; tick();
    bus.i_falling_edge_busy = 1'b0;
    msg(3);
    chk("ab_noresp_valid", 32'(bus.o_valid_rx),          0);
    chk("ab_noresp_enc",   32'(bus.o_encoded_SB_msg_rx), 0);

    // early START_REQ; response also collides with a wrapper clear
    msg(1);
    repeat (2) tick();
    bus.i_rx_d2c_pt_en = 1'b1; tick();
    bus.i_falling_edge_busy = 1'b1; bus.i_tx_valid = 1'b0; tick();
    chk("es_resp",      32'(bus.o_encoded_SB_msg_rx), 2);
    chk("es_valid_win", 32'(bus.o_valid_rx),          1);
    bus.i_falling_edge_busy = 1'b0;
    bus.i_rx_d2c_pt_en = 1'b0; repeat (2) tick();

`ifdef RX_D2C_PT_TIMEOUT_EN
    bus.i_rx_d2c_pt_en = 1'b1; tick();
    repeat (TO - 1) tick();
    chk("to_early", 32'(bus.o_timeout), 0);
    tick();
    chk("to_flag", 32'(bus.o_timeout),           1);
    chk("to_done", 32'(bus.o_rx_d2c_pt_done_rx), 1);
    bus.i_rx_d2c_pt_en = 1'b0; repeat (2) tick();
    chk("to_clear", 32'(bus.o_timeout), 0);
`endif

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if (bus.i_rx_d2c_pt_en) bus.i_rx_d2c_pt_en = ($urandom_range(0, 99) != 0);
      else                    bus.i_rx_d2c_pt_en = ($urandom_range(0, 3) == 0);
      bus.i_rx_msg_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 6) bus.i_decoded_SB_msg = W'(2 * $urandom_range(0, 3) + 1);
      else                          bus.i_decoded_SB_msg = W'($urandom_range(0, 15));
      bus.i_sb_data_pattern    = $urandom_range(0, 1);
      bus.i_sb_burst_count     = $urandom_range(0, 1);
      bus.i_sb_comparison_mode = $urandom_range(0, 1);
      bus.i_sb_clock_phase     = 2'($urandom_range(0, 3));
      bus.i_falling_edge_busy  = ($urandom_range(0, 3) == 0);
      bus.i_tx_valid           = $urandom_range(0, 1);
      bus.i_lane_errors        = NL'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
